// File: rtl/sq_meas_pkg.sv
// Shared definitions for the square-wave period/duty meter.
// Contents:
//   meas_state_e    per-channel FSM state (IDLE, ARM, MEAS)
//   DEF_*           default widths and timeout used by sq_meas_chan / sq_freq_duty_meter
package sq_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_e;

  localparam int          DEF_CH          = 2;
  localparam int          DEF_CNT_W       = 32;
  localparam int          DEF_CYC_W       = 16;
  // 1 s at 200 MHz
  localparam int unsigned DEF_TIMEOUT_CYC = 200_000_000;

endpackage

// File: rtl/sq_meas_chan.sv
// One measurement channel: synchronizer, rising-edge detect, IDLE/ARM/MEAS FSM,
// period/high accumulators with saturation and a no-edge timeout.
// Ports:
//   pll_clk, sys_rst_n   measurement clock, async active-low reset
//   wave_i               asynchronous square-wave input
//   start_i              one-cycle arm pulse (only used when CONTINUOUS=0)
//   meas_cycles_i        periods per window, sampled when a window is armed (0 -> 1)
//   period_total_o       ticks over the last completed window
//   high_total_o         high ticks over the last completed window
//   res_valid_o          one-cycle pulse when period/high totals were updated
//   timeout_o            one-cycle pulse when the window was aborted
//   busy_o               FSM in ARM or MEAS
//   state_o              current FSM state (debug)
// Output semantics: res_valid_o and timeout_o are single-cycle strobes with no
// back-pressure; the totals are valid from the res_valid_o cycle and held until
// the next res_valid_o.
module sq_meas_chan
  import sq_meas_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          CYC_W       = DEF_CYC_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic             pll_clk,
  input  logic             sys_rst_n,
  input  logic             wave_i,
  input  logic             start_i,
  input  logic [CYC_W-1:0] meas_cycles_i,
  output logic [CNT_W-1:0] period_total_o,
  output logic [CNT_W-1:0] high_total_o,
  output logic             res_valid_o,
  output logic             timeout_o,
  output logic             busy_o,
  output meas_state_e      state_o
);

  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  // input path: 2-FF synchronizer plus one registered copy for edge detect
  logic sync1_q, sync2_q, prev_q;
  logic rise;

  meas_state_e      state_q, state_d;
  logic [CYC_W-1:0] n_lat_q, n_lat_d;
  logic [CYC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] per_acc_q, per_acc_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] period_total_q, period_total_d;
  logic [CNT_W-1:0] high_total_q, high_total_d;
  logic             res_valid_q, res_valid_d;
  logic             timeout_q, timeout_d;

  logic [CYC_W-1:0] n_arm;
  logic             last_edge;
  logic             to_expire;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] high_inc;

  assign rise      = sync2_q & ~prev_q;
  assign n_arm     = (meas_cycles_i == '0) ? CYC_W'(1) : meas_cycles_i;
  // widened compare so edge_cnt+1 cannot wrap for n_lat at full scale
  assign last_edge = (({1'b0, edge_cnt_q} + (CYC_W+1)'(1)) == {1'b0, n_lat_q});
  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign per_inc   = (per_acc_q  == '1) ? per_acc_q  : per_acc_q  + CNT_W'(1);
  assign high_inc  = (high_acc_q == '1) ? high_acc_q : high_acc_q + CNT_W'(1);

  always_ff @(posedge pll_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      state_q        <= ST_IDLE;
      n_lat_q        <= '0;
      edge_cnt_q     <= '0;
      per_acc_q      <= '0;
      high_acc_q     <= '0;
      to_cnt_q       <= '0;
      period_total_q <= '0;
      high_total_q   <= '0;
      res_valid_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync1_q        <= wave_i;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      state_q        <= state_d;
      n_lat_q        <= n_lat_d;
      edge_cnt_q     <= edge_cnt_d;
      per_acc_q      <= per_acc_d;
      high_acc_q     <= high_acc_d;
      to_cnt_q       <= to_cnt_d;
      period_total_q <= period_total_d;
      high_total_q   <= high_total_d;
      res_valid_q    <= res_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    n_lat_d        = n_lat_q;
    edge_cnt_d     = edge_cnt_q;
    per_acc_d      = per_acc_q;
    high_acc_d     = high_acc_q;
    to_cnt_d       = to_cnt_q;
    period_total_d = period_total_q;
    high_total_d   = high_total_q;
    res_valid_d    = 1'b0;
    timeout_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CONTINUOUS || start_i) begin
          state_d    = ST_ARM;
          n_lat_d    = n_arm;
          edge_cnt_d = '0;
          per_acc_d  = '0;
          high_acc_d = '0;
          to_cnt_d   = '0;
        end
      end
      ST_ARM: begin
        if (rise) begin
          // opening edge cycle is counted as one high tick
          state_d    = ST_MEAS;
          per_acc_d  = CNT_W'(1);
          high_acc_d = CNT_W'(1);
          edge_cnt_d = '0;
          to_cnt_d   = '0;
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_MEAS: begin
        if (rise) begin
          to_cnt_d = '0;
          if (last_edge) begin
            // closing edge tick is not part of this window
            period_total_d = per_acc_q;
            high_total_d   = high_acc_q;
            res_valid_d    = 1'b1;
            if (CONTINUOUS) begin
              // the closing edge opens the next window, so no edge is lost
              state_d    = ST_MEAS;
              per_acc_d  = CNT_W'(1);
              high_acc_d = CNT_W'(1);
              edge_cnt_d = '0;
              n_lat_d    = n_arm;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            edge_cnt_d = edge_cnt_q + CYC_W'(1);
            per_acc_d  = per_inc;
            high_acc_d = high_inc;
          end
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d  = to_cnt_q + TO_W'(1);
          per_acc_d = per_inc;
          if (sync2_q) begin
            high_acc_d = high_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign period_total_o = period_total_q;
  assign high_total_o   = high_total_q;
  assign res_valid_o    = res_valid_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign state_o        = state_q;

endmodule

// File: rtl/sq_freq_duty_meter.sv
// Multi-channel square-wave period/duty meter on the 200 MHz PLL clock.
// Each channel counts N full input periods and reports the total ticks and
// the high ticks over that window; frequency and duty are derived downstream.
// Ports:
//   pll_clk, sys_rst_n   measurement clock, async active-low reset
//   wave_in[CH]          asynchronous square-wave inputs
//   start                one-cycle pulse arming all idle channels (CONTINUOUS=0)
//   meas_cycles          periods per window, sampled at arm (0 -> 1)
//   period_total         per-channel window ticks, channel c at [c*CNT_W +: CNT_W]
//   high_total           per-channel high ticks, same layout
//   res_valid[CH]        one-cycle result strobe per channel
//   timeout[CH]          one-cycle abort strobe per channel
//   busy[CH]             channel in ARM or MEAS
//   chan_state_dbg       per-channel FSM state, channel c at [2*c +: 2] (debug)
module sq_freq_duty_meter
  import sq_meas_pkg::*;
#(
  parameter int          CH          = DEF_CH,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          CYC_W       = DEF_CYC_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic                pll_clk,
  input  logic                sys_rst_n,
  input  logic [CH-1:0]       wave_in,
  input  logic                start,
  input  logic [CYC_W-1:0]    meas_cycles,
  output logic [CH*CNT_W-1:0] period_total,
  output logic [CH*CNT_W-1:0] high_total,
  output logic [CH-1:0]       res_valid,
  output logic [CH-1:0]       timeout,
  output logic [CH-1:0]       busy,
  output logic [2*CH-1:0]     chan_state_dbg
);

  for (genvar c = 0; c < CH; c++) begin : g_chan
    meas_state_e chan_state;

    sq_meas_chan #(
      .CNT_W      (CNT_W),
      .CYC_W      (CYC_W),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .CONTINUOUS (CONTINUOUS)
    ) u_chan (
      .pll_clk       (pll_clk),
      .sys_rst_n     (sys_rst_n),
      .wave_i        (wave_in[c]),
      .start_i       (start),
      .meas_cycles_i (meas_cycles),
      .period_total_o(period_total[c*CNT_W +: CNT_W]),
      .high_total_o  (high_total[c*CNT_W +: CNT_W]),
      .res_valid_o   (res_valid[c]),
      .timeout_o     (timeout[c]),
      .busy_o        (busy[c]),
      .state_o       (chan_state)
    );

    assign chan_state_dbg[2*c +: 2] = chan_state;
  end

endmodule

// File: tb/tb_sq_freq_duty_meter.sv
`timescale 1ns/1ps
module tb_sq_freq_duty_meter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #2.5 clk = ~clk;

  // ---------------- DUT signals ----------------
  // one-shot instance (os) and continuous instance (ct), both with a 1000-tick timeout
  logic        start_os = 1'b0;
  logic        start_ct = 1'b0;
  logic [15:0] mc_os = 16'd10;
  logic [15:0] mc_ct = 16'd1;
  logic [63:0] pt_os, ht_os, pt_ct, ht_ct;
  logic [1:0]  rv_os, to_os, busy_os, rv_ct, to_ct, busy_ct;
  logic [3:0]  st_os, st_ct;
  logic [3:0]  wave = '0;

  sq_freq_duty_meter #(
    .CH(2), .CNT_W(32), .CYC_W(16), .TIMEOUT_CYC(1000), .CONTINUOUS(1'b0)
  ) dut_os (
    .pll_clk(clk), .sys_rst_n(sys_rst_n), .wave_in(wave[1:0]), .start(start_os),
    .meas_cycles(mc_os), .period_total(pt_os), .high_total(ht_os), .res_valid(rv_os),
    .timeout(to_os), .busy(busy_os), .chan_state_dbg(st_os)
  );

  sq_freq_duty_meter #(
    .CH(2), .CNT_W(32), .CYC_W(16), .TIMEOUT_CYC(1000), .CONTINUOUS(1'b1)
  ) dut_ct (
    .pll_clk(clk), .sys_rst_n(sys_rst_n), .wave_in(wave[3:2]), .start(start_ct),
    .meas_cycles(mc_ct), .period_total(pt_ct), .high_total(ht_ct), .res_valid(rv_ct),
    .timeout(to_ct), .busy(busy_ct), .chan_state_dbg(st_ct)
  );

  // ---------------- wave generators (tick-exact, updated on negedge) ----------------
  // index 0,1 -> dut_os ch0,ch1; 2,3 -> dut_ct ch0,ch1
  int gen_per[4] = '{200, 200, 200, 200};
  int gen_hi[4]  = '{100, 100, 100, 100};
  int gen_ph[4]  = '{0, 0, 0, 0};
  bit gen_en[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (gen_en[g]) begin
        wave[g] = (gen_ph[g] < gen_hi[g]);
        gen_ph[g] = (gen_ph[g] + 1) % gen_per[g];
      end else begin
        wave[g] = 1'b0;
        gen_ph[g] = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit flag(input int sel);
    case (sel)
      0: return rv_os[0];
      1: return rv_os[1];
      2: return to_os[1];
      3: return rv_ct[0];
      default: return to_ct[1];
    endcase
  endfunction

  // ticks until the selected strobe is seen; -1 when the budget expires
  task automatic wait_flag(input int sel, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (flag(sel)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start_os();
    @(negedge clk);
    start_os = 1'b1;
    @(negedge clk);
    start_os = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int n;
  int cnt0, cnt1, cnt_to, cnt_any;
  logic [31:0] p0, h0, p1, h1;

  initial begin
    gen_en[2] = 1'b1;  // continuous ch0: 1 MHz 50%
    repeat (5) @(negedge clk);

    // reset state
    check("rst_pt_os", pt_os, 64'd0);
    check("rst_ht_os", ht_os, 64'd0);
    check("rst_rv_os", {62'd0, rv_os}, 64'd0);
    check("rst_busy_os", {62'd0, busy_os}, 64'd0);
    check("rst_busy_ct", {62'd0, busy_ct}, 64'd0);
    check("rst_to_ct", {62'd0, to_ct}, 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    // T1: one-shot, ch0 1 MHz 50%, N=10; ch1 held low -> timeout
    gen_en[0] = 1'b1;
    repeat (300) @(negedge clk);
    start_os = 1'b1;
    tick();
    check("t1_busy_after_start", {62'd0, busy_os}, 64'd3);
    start_os = 1'b0;
    wait_flag(2, 3000, n);
    check("t1_timeout_latency", n, 1000);
    check("t1_ch1_period_unchanged", pt_os[63:32], 64'd0);
    check("t1_ch1_high_unchanged", ht_os[63:32], 64'd0);
    check("t1_ch1_idle_after_timeout", busy_os[1], 1'b0);
    wait_flag(0, 4000, n);
    check("t1_valid_seen", (n > 0), 1'b1);
    check("t1_period", pt_os[31:0], 64'd2000);
    check("t1_high", ht_os[31:0], 64'd1000);
    check("t1_busy_drop", busy_os[0], 1'b0);
    cnt_any = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rv_os != 2'b00) cnt_any++;
    end
    check("t1_single_valid", cnt_any, 0);

    // T2: no start -> no result; then ch0 25%, ch1 400 kHz 50%, N=4
    mc_os = 16'd4;
    gen_hi[0] = 50;
    gen_per[1] = 500;
    gen_hi[1] = 250;
    gen_en[1] = 1'b1;
    cnt_any = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rv_os != 2'b00 || busy_os != 2'b00) cnt_any++;
    end
    check("t2_idle_without_start", cnt_any, 0);
    pulse_start_os();
    mc_os = 16'd1;  // must not affect the armed window
    cnt0 = 0; cnt1 = 0; cnt_to = 0;
    p0 = '0; h0 = '0; p1 = '0; h1 = '0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (i == 300) start_os = 1'b1;  // start while busy
      if (i == 301) start_os = 1'b0;
      if (rv_os[0]) begin
        cnt0++;
        if (cnt0 == 1) begin p0 = pt_os[31:0]; h0 = ht_os[31:0]; end
      end
      if (rv_os[1]) begin
        cnt1++;
        if (cnt1 == 1) begin p1 = pt_os[63:32]; h1 = ht_os[63:32]; end
      end
      if (to_os != 2'b00) cnt_to++;
    end
    check("t2_ch0_valids", cnt0, 1);
    check("t2_ch1_valids", cnt1, 1);
    check("t2_timeouts", cnt_to, 0);
    check("t2_ch0_period", p0, 64'd800);
    check("t2_ch0_high", h0, 64'd200);
    check("t2_ch1_period", p1, 64'd2000);
    check("t2_ch1_high", h1, 64'd1000);
    check("t2_hold_ch0", pt_os[31:0], 64'd800);

    // T3: meas_cycles = 0 behaves as N = 1
    mc_os = 16'd0;
    pulse_start_os();
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rv_os[0]) begin cnt0++; p0 = pt_os[31:0]; h0 = ht_os[31:0]; end
      if (rv_os[1]) begin cnt1++; p1 = pt_os[63:32]; h1 = ht_os[63:32]; end
    end
    check("t3_ch0_valids", cnt0, 1);
    check("t3_ch1_valids", cnt1, 1);
    check("t3_ch0_period", p0, 64'd200);
    check("t3_ch0_high", h0, 64'd50);
    check("t3_ch1_period", p1, 64'd500);
    check("t3_ch1_high", h1, 64'd250);

    // T4: continuous, 1 MHz 50%, N=1 -> result every 200 ticks
    for (int k = 0; k < 5; k++) exp_q.push_back(32'd200);
    wait_flag(3, 1000, n);
    check("t4_first_valid", (n > 0), 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_flag(3, 400, n);
      check("t4_gap", n, 200);
      check("t4_period", pt_ct[31:0], exp_q.pop_front());
      check("t4_high", ht_ct[31:0], 64'd100);
    end
    // continuous ch1 held low: timeout, re-arm after one idle cycle
    wait_flag(4, 1500, n);
    check("t4_timeout_seen", (n > 0), 1'b1);
    wait_flag(4, 1500, n);
    check("t4_timeout_rearm_gap", n, 1001);
    check("t4_ch1_period_unchanged", pt_ct[63:32], 64'd0);

    // T5: reset asserted mid-measurement
    mc_os = 16'd10;
    pulse_start_os();
    repeat (500) tick();
    check("t5_busy_mid_meas", busy_os[0], 1'b1);
    @(posedge clk);
    #1.3 sys_rst_n = 1'b0;
    #1;
    check("t5_rst_pt_os", pt_os, 64'd0);
    check("t5_rst_ht_os", ht_os, 64'd0);
    check("t5_rst_busy_os", {62'd0, busy_os}, 64'd0);
    check("t5_rst_flags_os", {60'd0, rv_os, to_os}, 64'd0);
    check("t5_rst_pt_ct", pt_ct, 64'd0);
    check("t5_rst_busy_ct", {62'd0, busy_ct}, 64'd0);
    check("t5_rst_state_os", {60'd0, st_os}, 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
